// File: rtl/vga_text_display.sv
// rtl/vga_text_display.sv - 80x30 text-mode scan-out engine with 640x480 VGA timing
module vga_text_display #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixelTick,
    output logic [15:0] displayAddr,
    input  logic [31:0] displayData,
    output logic [11:0] fontAddr,
    input  logic [7:0]  fontRow,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        hsync,
    output logic        vsync,
    output logic        frameEnd
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [6:0] COL_LIM  = 7'(COLS);
    localparam logic [4:0] ROW_LIM  = 5'(ROWS);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [9:0]    h_count;
    logic [9:0]    v_count;
    logic          line_end;
    logic          frame_wrap;

    logic [6:0]    col;
    logic [4:0]    row;
    logic          visible;
    logic          hs0;
    logic          vs0;
    logic [15:0]   addr_calc;

    logic [16:0]   cell_reg;
    logic [2:0]    px1;
    logic [3:0]    gr1;
    logic          vis1;
    logic          hs1;
    logic          vs1;

    logic          pix_on;
    logic [3:0]    colour;
    logic [11:0]   rgb_next;
    logic [11:0]   rgb;

    logic [FW-1:0] frame_count;
    logic          blink_phase;

    // Upper cell bits carry nothing the display uses.
    logic          unused_cell_bits;
    assign unused_cell_bits = ^displayData[31:17];

    // IRGB colour to 4-bit-per-channel RGB: intensity lifts both lit and dark levels.
    function automatic logic [11:0] expand_colour(input logic [3:0] c);
        logic [3:0] lit;
        logic [3:0] dim;
        lit = c[3] ? 4'hF : 4'hA;
        dim = c[3] ? 4'h5 : 4'h0;
        return {c[2] ? lit : dim, c[1] ? lit : dim, c[0] ? lit : dim};
    endfunction

    assign line_end   = (h_count == H_LAST);
    assign frame_wrap = line_end && (v_count == V_LAST);

    // Raster position: horizontal counter with vertical carry at line end.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (pixelTick) begin
            if (line_end) begin
                h_count <= 10'd0;
                v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // Stage 0: cell address (row*80 as shifts) and raw syncs from the counters.
    always_comb begin
        col       = h_count[9:3];
        row       = v_count[8:4];
        visible   = (h_count < H_VIS) && (v_count < V_VIS) && (col < COL_LIM) && (row < ROW_LIM);
        addr_calc = ({11'd0, row} << 6) + ({11'd0, row} << 4) + {9'd0, col};
        displayAddr = visible ? addr_calc : 16'd0;
        hs0 = !((h_count >= HS_START) && (h_count < HS_END));
        vs0 = !((v_count >= VS_START) && (v_count < VS_END));
    end

    // Stage 1: capture the cell word together with its pixel position and syncs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cell_reg <= 17'd0;
            px1      <= 3'd0;
            gr1      <= 4'd0;
            vis1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
        end else if (pixelTick) begin
            cell_reg <= displayData[16:0];
            px1      <= h_count[2:0];
            gr1      <= v_count[3:0];
            vis1     <= visible;
            hs1      <= hs0;
            vs1      <= vs0;
        end
    end

    assign fontAddr = {cell_reg[7:0], gr1};

    // Stage 2 select: glyph bit (MSB leftmost), blink masking, fg/bg choice.
    always_comb begin
        pix_on   = fontRow[3'd7 - px1] && !(cell_reg[16] && blink_phase);
        colour   = pix_on ? cell_reg[11:8] : cell_reg[15:12];
        rgb_next = vis1 ? expand_colour(colour) : 12'h000;
    end

    // Stage 2: output registers, syncs kept aligned with the pixel they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb   <= 12'h000;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pixelTick) begin
            rgb   <= rgb_next;
            hsync <= hs1;
            vsync <= vs1;
        end
    end

    assign vgaRed   = rgb[11:8];
    assign vgaGreen = rgb[7:4];
    assign vgaBlue  = rgb[3:0];

    // Frame strobe: high for the single clock of the wrapping tick only.
    always_ff @(posedge clock) begin
        if (reset) begin
            frameEnd <= 1'b0;
        end else begin
            frameEnd <= pixelTick && frame_wrap;
        end
    end

    // Blink timebase: toggles phase every BLINK_FRAMES frame wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            blink_phase <= 1'b0;
        end else if (pixelTick && frame_wrap) begin
            if (frame_count == FRAME_LAST) begin
                frame_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_count <= frame_count + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_text_display.sv
// tb/tb_vga_text_display.sv - directed self-checking bench for vga_text_display
`timescale 1ns/1ps
module tb_vga_text_display;

    logic clock;
    int   tests;
    int   fails;

    // Instance A: full 640x480 timing.
    logic        rst_a, tick_a;
    logic [15:0] addr_a;
    logic [31:0] data_a;
    logic [11:0] faddr_a;
    logic [7:0]  frow_a;
    logic [3:0]  red_a, green_a, blue_a;
    logic        hs_a, vs_a, fe_a;

    // Instance B: short lines, full frame height.
    logic        rst_b, tick_b;
    logic [15:0] addr_b;
    logic [31:0] data_b;
    logic [11:0] faddr_b;
    logic [7:0]  frow_b;
    logic [3:0]  red_b, green_b, blue_b;
    logic        hs_b, vs_b, fe_b;

    // Instance C: tiny frame for the blink timebase.
    logic        rst_c, tick_c;
    logic [15:0] addr_c;
    logic [31:0] data_c;
    logic [11:0] faddr_c;
    logic [7:0]  frow_c;
    logic [3:0]  red_c, green_c, blue_c;
    logic        hs_c, vs_c, fe_c;

    vga_text_display u_dut_a (
        .clock(clock), .reset(rst_a), .pixelTick(tick_a),
        .displayAddr(addr_a), .displayData(data_a),
        .fontAddr(faddr_a), .fontRow(frow_a),
        .vgaRed(red_a), .vgaGreen(green_a), .vgaBlue(blue_a),
        .hsync(hs_a), .vsync(vs_a), .frameEnd(fe_a)
    );

    vga_text_display #(.H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_dut_b (
        .clock(clock), .reset(rst_b), .pixelTick(tick_b),
        .displayAddr(addr_b), .displayData(data_b),
        .fontAddr(faddr_b), .fontRow(frow_b),
        .vgaRed(red_b), .vgaGreen(green_b), .vgaBlue(blue_b),
        .hsync(hs_b), .vsync(vs_b), .frameEnd(fe_b)
    );

    vga_text_display #(.H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                       .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_dut_c (
        .clock(clock), .reset(rst_c), .pixelTick(tick_c),
        .displayAddr(addr_c), .displayData(data_c),
        .fontAddr(faddr_c), .fontRow(frow_c),
        .vgaRed(red_c), .vgaGreen(green_c), .vgaBlue(blue_c),
        .hsync(hs_c), .vsync(vs_c), .frameEnd(fe_c)
    );

    // Screen memory and font ROM models: only cell 1 and glyph row 0x413 are non-zero for A.
    always_comb begin
        data_a = (addr_a == 16'd1) ? 32'h0000_1F41 : 32'h0000_0000;
        frow_a = (faddr_a == 12'h413) ? 8'h80 : 8'h00;
    end
    assign data_b = 32'h0000_0000;
    assign frow_b = 8'h00;
    assign data_c = 32'h0001_0F41;
    assign frow_c = 8'hFF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_first, hs_lows, vs_first, vs_lows, fe_count, fe_at, f;
        tests = 0;
        fails = 0;
        rst_a = 1'b1; tick_a = 1'b0;
        rst_b = 1'b1; tick_b = 1'b0;
        rst_c = 1'b1; tick_c = 1'b0;
        repeat (3) step();

        // Reset state, with ticks enabled to show reset wins.
        tick_a = 1'b1;
        step();
        chk("rst_rgb",   32'({red_a, green_a, blue_a}), 32'h000);
        chk("rst_hsync", 32'(hs_a), 32'd1);
        chk("rst_vsync", 32'(vs_a), 32'd1);
        chk("rst_frame", 32'(fe_a), 32'd0);
        chk("rst_addr",  32'(addr_a), 32'd0);
        chk("rst_faddr", 32'(faddr_a), 32'h000);

        // Line 0: address edges and hsync placement (output of h lags two ticks).
        rst_a = 1'b0;
        hs_first = -1;
        hs_lows  = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            if (!hs_a) begin
                hs_lows++;
                if (hs_first < 0) hs_first = k;
            end
            if (k == 639) chk("addr_639_0", 32'(addr_a), 32'd79);
            if (k == 640) chk("addr_640_0", 32'(addr_a), 32'd0);
        end
        chk("hs_first", 32'(hs_first), 32'd658);
        chk("hs_width", 32'(hs_lows), 32'd96);
        chk("vs_line0", 32'(vs_a), 32'd1);

        // Glyph pixel at (8,3) lit in fg white, then bg blue at (9,3).
        for (int k = 801; k <= 2410; k++) step();
        chk("pix_fg",    32'({red_a, green_a, blue_a}), 32'hFFF);
        chk("pix_faddr", 32'(faddr_a), 32'h413);

        // Stall ten clocks: nothing moves, then resume from the same pixel.
        tick_a = 1'b0;
        repeat (10) step();
        chk("stall_rgb", 32'({red_a, green_a, blue_a}), 32'hFFF);
        tick_a = 1'b1;
        step();
        chk("pix_bg1", 32'({red_a, green_a, blue_a}), 32'h00A);
        step();
        chk("pix_bg2", 32'({red_a, green_a, blue_a}), 32'h00A);
        repeat (3) step();
        chk("stall_addr_hold", 32'(addr_a), 32'd1);
        step();
        chk("stall_addr_next", 32'(addr_a), 32'd2);

        // Mid-frame reset, then restart from (0,0).
        rst_a = 1'b1;
        step();
        chk("mrst_rgb",   32'({red_a, green_a, blue_a}), 32'h000);
        chk("mrst_hsync", 32'(hs_a), 32'd1);
        chk("mrst_vsync", 32'(vs_a), 32'd1);
        chk("mrst_addr",  32'(addr_a), 32'd0);
        rst_a = 1'b0;
        for (int n = 1; n <= 28017; n++) begin
            step();
            if (n == 7)  chk("restart_addr_h7", 32'(addr_a), 32'd0);
            if (n == 8)  chk("restart_addr_h8", 32'(addr_a), 32'd1);
            if (n == 10) chk("restart_rgb_h8",  32'({red_a, green_a, blue_a}), 32'h00A);
        end
        chk("addr_17_35", 32'(addr_a), 32'd162);
        tick_a = 1'b0;

        // Full frame on B: sync counts, vsync placement, last-row address, frame strobe.
        rst_b  = 1'b0;
        tick_b = 1'b1;
        hs_lows = 0; vs_lows = 0; vs_first = -1; fe_count = 0; fe_at = -1;
        for (int k = 1; k <= 6300; k++) begin
            step();
            if (!hs_b) hs_lows++;
            if (!vs_b) begin
                vs_lows++;
                if (vs_first < 0) vs_first = k;
            end
            if (fe_b) begin
                fe_count++;
                fe_at = k;
            end
            if (k == 5748) chk("addr_row29", 32'(addr_b), 32'd2320);
        end
        chk("b_hs_lows",  32'(hs_lows), 32'd1050);
        chk("b_vs_lows",  32'(vs_lows), 32'd24);
        chk("b_vs_first", 32'(vs_first), 32'd5882);
        chk("b_fe_count", 32'(fe_count), 32'd1);
        chk("b_fe_at",    32'(fe_at), 32'd6300);
        tick_b = 1'b0;
        step();
        chk("b_fe_width", 32'(fe_b), 32'd0);

        // Blink on C: pixel (0,0) of each frame; 32 frames shown, 32 hidden.
        rst_c  = 1'b0;
        tick_c = 1'b1;
        for (int k = 1; k <= 64 * 240 + 2; k++) begin
            step();
            if (k % 240 == 2) begin
                f = k / 240;
                if (f == 0 || f == 31 || f == 32 || f == 63 || f == 64)
                    chk($sformatf("blink_f%0d", f), 32'({red_c, green_c, blue_c}),
                        (((f / 32) % 2) == 0) ? 32'hFFF : 32'h000);
            end
        end
        tick_c = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
